el2_bp_ghr_ckpt: RTL
====================

# el2_bp_ghr_ckpt

Speculative global-history (GHR) manager for the EL2 branch predictor. Produces the fetch-side GHR consumed by the BHT index hash. Checkpoints the GHR on every conditional-branch prediction and restores it when a branch resolves as mispredicted. Also maintains the committed GHR from in-order retirement. Sits between the IFU prediction stage (writer of history) and the EXU/retire resolution paths.

## Interface

- GHR_SIZE, default pt.BHT_GHR_SIZE (8): history width in bits.
- DEPTH, default 4: in-flight checkpoint entries; power of 2, ≥2.
- IDW, default $clog2(DEPTH): checkpoint id width.

- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- pred_valid  in  1  fetch predicts a conditional branch this cycle.
- pred_taken  in  1  predicted direction.
- pred_ready  out  1  push accepted this cycle. Equals !full & !flush & !(resolve_valid & resolve_mispredict).
- pred_id  out  IDW  id assigned to the accepted prediction (current write pointer).
- fghr  out  GHR_SIZE  speculative GHR, registered.
- resolve_valid  in  1  a branch has resolved in EXU.
- resolve_id  in  IDW  id of the resolved branch.
- resolve_taken  in  1  actual direction.
- resolve_mispredict  in  1  actual direction differs from predicted.
- ret_valid  in  1  oldest in-flight branch retires.
- flush  in  1  pipeline flush (exception/interrupt); discard all speculation.
- cghr  out  GHR_SIZE  committed GHR, registered.
- count  out  IDW+1  in-flight entries.
- err  out  1  sticky protocol error.

## Operation

- Storage per entry: ghr_before[GHR_SIZE], dir. Pointers: rd_ptr and wr_ptr are IDW+1 bits with a wrap bit. full = (count == DEPTH); empty = (count == 0).
- Push (pred_valid & pred_ready):
  - entry[wr_ptr] ← {fghr, pred_taken}.
  - wr_ptr++.
  - fghr ← {fghr[GHR_SIZE-2:0], pred_taken}.
- Resolve:
  - An id is in flight iff it lies in [rd_ptr, wr_ptr) modulo DEPTH.
  - Correct resolve: no state change.
  - Mispredict:
    - fghr ← {entry[id].ghr_before[GHR_SIZE-2:0], resolve_taken}.
    - entry[id].dir ← resolve_taken.
    - wr_ptr ← id + 1, keeping the wrap bit consistent so younger entries are squashed.
  - Resolve on an id not in flight: ignored; err ← 1.
- Retire (ret_valid):
  - cghr ← {cghr[GHR_SIZE-2:0], entry[rd_ptr].dir}; rd_ptr++.
  - If a mispredict to the same id occurs in the same cycle, the corrected direction is used.
  - Retire while empty: ignored; err ← 1.
- Flush:
  - fghr ← cghr_next, which includes any retire in the same cycle.
  - wr_ptr ← rd_ptr_next. count becomes 0.
  - Pending resolve is ignored.
- Priority: flush > mispredict > push. Retire is independent and is always applied.
- pred_ready has a combinational path from flush and resolve_mispredict.

## Timing

- Reset values: fghr = 0, cghr = 0, pointers = 0, count = 0, err = 0, pred_id = 0, pred_ready = 1 (when flush and mispredict are low).
- fghr, cghr, count and err update on the clock edge after the event. Latency is 1 cycle.
- pred_id is valid in the same cycle as pred_valid.
- Full with simultaneous retire: push is still refused. pred_ready is computed from the current count.
- Pointer wrap: full/empty use the wrap bit. Checkpoint ids repeat every DEPTH pushes.
- Reset mid-operation: all state is cleared immediately (asynchronous). Entry contents need not be reset.

## Structure

- Shared el2_pkg holds:
  - typedef el2_ghr_ckpt_t {ghr_before, dir}.
  - The GHR shift function, so the IFU and this block share one definition.
- One natural sub-module: el2_ghr_ckpt_fifo. It holds the circular buffer, pointers and in-flight check, and supports pointer rollback for the squash.
- Top level holds fghr/cghr update logic and arbitration.

## Test plan

- Reset, then 3 pushes taken, taken, not-taken (GHR_SIZE=8) → fghr = 8'b0000_0110, pred_id sequence 0,1,2, count = 3.
- Continuing from the previous scenario, mispredict on id 1 with resolve_taken = 0 → fghr = 8'b0000_0010, count = 2, and a next push gets pred_id = 2.
- Fill to DEPTH=4 → pred_ready = 0. A push with retire in the same cycle is refused. Next cycle count = 3 and pred_ready = 1.
- Retire 2 entries after the mispredict scenario → cghr = 8'b0000_0010, i.e. the corrected dir is used.
- Flush with 3 in flight and a simultaneous retire of a taken entry → fghr = cghr = previous cghr shifted with 1, count = 0.
- Error cases: resolve on id 3 with only ids 0–1 in flight, and retire while empty → state unchanged, err = 1 and it stays set until reset.

Source files
------------

// File: rtl/el2_bp_ghr_ckpt_pkg.sv
// Shared types and the GHR shift helper used by the IFU and the GHR checkpoint manager.
package el2_bp_ghr_ckpt_pkg;

    localparam int BHT_GHR_SIZE = 8;

    typedef struct packed {
        logic [BHT_GHR_SIZE-1:0] ghr_before;
        logic                    dir;
    } el2_ghr_ckpt_t;

    function automatic logic [BHT_GHR_SIZE-1:0] ghr_shift(
        input logic [BHT_GHR_SIZE-1:0] ghr,
        input logic                    dir
    );
        return {ghr[BHT_GHR_SIZE-2:0], dir};
    endfunction

endpackage

// File: rtl/el2_bp_ghr_ckpt_if.sv
// Prediction / resolution / retire bus between the IFU, EXU and the GHR checkpoint manager.
interface el2_bp_ghr_ckpt_if
    import el2_bp_ghr_ckpt_pkg::*;
#(
    parameter int GHR_SIZE = BHT_GHR_SIZE,
    parameter int DEPTH    = 4,
    parameter int IDW      = $clog2(DEPTH)
);
    logic                pred_valid;
    logic                pred_taken;
    logic                pred_ready;
    logic [IDW-1:0]      pred_id;
    logic [GHR_SIZE-1:0] fghr;
    logic                resolve_valid;
    logic [IDW-1:0]      resolve_id;
    logic                resolve_taken;
    logic                resolve_mispredict;
    logic                ret_valid;
    logic                flush;
    logic [GHR_SIZE-1:0] cghr;
    logic [IDW:0]        count;
    logic                err;

    modport master (
        output pred_valid, pred_taken, resolve_valid, resolve_id, resolve_taken,
               resolve_mispredict, ret_valid, flush,
        input  pred_ready, pred_id, fghr, cghr, count, err
    );

    modport slave (
        input  pred_valid, pred_taken, resolve_valid, resolve_id, resolve_taken,
               resolve_mispredict, ret_valid, flush,
        output pred_ready, pred_id, fghr, cghr, count, err
    );

endinterface

// File: rtl/el2_bp_ghr_ckpt_fifo.sv
// Circular checkpoint buffer with wrap-bit pointers, in-flight id check and
// write-pointer rollback used to squash entries younger than a mispredicted branch.
module el2_bp_ghr_ckpt_fifo
    import el2_bp_ghr_ckpt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDW   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  el2_ghr_ckpt_t           push_entry,
    input  logic                    pop,
    input  logic                    flush,
    input  logic                    rb_valid,
    input  logic [IDW-1:0]          res_id,
    input  logic                    rb_dir,
    output logic                    in_flight,
    output logic [BHT_GHR_SIZE-1:0] rb_ghr,
    output logic                    rd_dir,
    output logic [IDW-1:0]          rd_idx,
    output logic [IDW-1:0]          wr_idx,
    output logic [IDW:0]            count,
    output logic                    full,
    output logic                    empty
);

    localparam logic [IDW:0] PTR_ONE  = (IDW+1)'(1);
    localparam logic [IDW:0] FULL_CNT = (IDW+1)'(DEPTH);

    logic [IDW:0]   rd_ptr_r;
    logic [IDW:0]   wr_ptr_r;
    logic [IDW:0]   count_r;
    logic [IDW:0]   rd_ptr_nxt_s;
    logic [IDW:0]   wr_ptr_nxt_s;
    logic [IDW-1:0] offset_s;
    el2_ghr_ckpt_t  mem_r [DEPTH];

    // Age of the resolving id relative to the oldest entry; it is in flight iff younger than count.
    always_comb begin
        offset_s  = res_id - rd_ptr_r[IDW-1:0];
        in_flight = ({1'b0, offset_s} < count_r);
    end

    // Next pointers: flush collapses wr onto the post-retire rd, rollback lands just past the id.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        if (pop) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (flush) begin
            wr_ptr_nxt_s = rd_ptr_nxt_s;
        end else if (rb_valid) begin
            wr_ptr_nxt_s = rd_ptr_r + {1'b0, offset_s} + PTR_ONE;
        end else if (push) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= wr_ptr_nxt_s - rd_ptr_nxt_s;
        end
    end

    // Checkpoint storage; contents are only meaningful between rd and wr, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r[IDW-1:0]] <= push_entry;
        end else if (rb_valid) begin
            mem_r[res_id].dir <= rb_dir;
        end
    end

    assign rb_ghr = mem_r[res_id].ghr_before;
    assign rd_dir = mem_r[rd_ptr_r[IDW-1:0]].dir;
    assign rd_idx = rd_ptr_r[IDW-1:0];
    assign wr_idx = wr_ptr_r[IDW-1:0];
    assign count  = count_r;
    assign full   = (count_r == FULL_CNT);
    assign empty  = (count_r == (IDW+1)'(0));

endmodule

// File: rtl/el2_bp_ghr_ckpt.sv
// Speculative / committed global-history manager: checkpoints fghr per conditional
// prediction, restores it on mispredict, and shifts cghr on in-order retire.
module el2_bp_ghr_ckpt
    import el2_bp_ghr_ckpt_pkg::*;
#(
    parameter int GHR_SIZE = BHT_GHR_SIZE,
    parameter int DEPTH    = 4,
    parameter int IDW      = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    el2_bp_ghr_ckpt_if.slave  bus
);

    logic                full_s;
    logic                empty_s;
    logic                in_flight_s;
    logic                rd_dir_s;
    logic [IDW-1:0]      rd_idx_s;
    logic [IDW-1:0]      wr_idx_s;
    logic [IDW:0]        count_s;
    logic [GHR_SIZE-1:0] rb_ghr_s;

    logic                mp_req_s;
    logic                pred_ready_s;
    logic                push_s;
    logic                mp_s;
    logic                pop_s;
    logic                ret_dir_s;
    logic                err_set_s;
    logic [GHR_SIZE-1:0] fghr_nxt_s;
    logic [GHR_SIZE-1:0] cghr_nxt_s;
    el2_ghr_ckpt_t       push_entry_s;

    logic [GHR_SIZE-1:0] fghr_r;
    logic [GHR_SIZE-1:0] cghr_r;
    logic                err_r;

    // Arbitration: flush beats mispredict beats push; retire always proceeds when non-empty.
    always_comb begin
        mp_req_s     = bus.resolve_valid & bus.resolve_mispredict;
        pred_ready_s = ~full_s & ~bus.flush & ~mp_req_s;
        push_s       = bus.pred_valid & pred_ready_s;
        mp_s         = mp_req_s & in_flight_s & ~bus.flush;
        pop_s        = bus.ret_valid & ~empty_s;
        err_set_s    = (bus.resolve_valid & ~in_flight_s & ~bus.flush) |
                       (bus.ret_valid & empty_s);
        push_entry_s = '{ghr_before: fghr_r, dir: bus.pred_taken};
        // A same-cycle correction of the retiring entry must reach cghr.
        if (mp_s && (bus.resolve_id == rd_idx_s)) begin
            ret_dir_s = bus.resolve_taken;
        end else begin
            ret_dir_s = rd_dir_s;
        end
    end

    // Next committed and speculative history.
    always_comb begin
        if (pop_s) begin
            cghr_nxt_s = ghr_shift(cghr_r, ret_dir_s);
        end else begin
            cghr_nxt_s = cghr_r;
        end
        if (bus.flush) begin
            fghr_nxt_s = cghr_nxt_s;
        end else if (mp_s) begin
            fghr_nxt_s = ghr_shift(rb_ghr_s, bus.resolve_taken);
        end else if (push_s) begin
            fghr_nxt_s = ghr_shift(fghr_r, bus.pred_taken);
        end else begin
            fghr_nxt_s = fghr_r;
        end
    end

    // History registers and the sticky protocol-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fghr_r <= '0;
            cghr_r <= '0;
            err_r  <= 1'b0;
        end else begin
            fghr_r <= fghr_nxt_s;
            cghr_r <= cghr_nxt_s;
            err_r  <= err_r | err_set_s;
        end
    end

    el2_bp_ghr_ckpt_fifo #(
        .DEPTH (DEPTH),
        .IDW   (IDW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (bus.flush),
        .rb_valid   (mp_s),
        .res_id     (bus.resolve_id),
        .rb_dir     (bus.resolve_taken),
        .in_flight  (in_flight_s),
        .rb_ghr     (rb_ghr_s),
        .rd_dir     (rd_dir_s),
        .rd_idx     (rd_idx_s),
        .wr_idx     (wr_idx_s),
        .count      (count_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    assign bus.pred_ready = pred_ready_s;
    assign bus.pred_id    = wr_idx_s;
    assign bus.fghr       = fghr_r;
    assign bus.cghr       = cghr_r;
    assign bus.count      = count_s;
    assign bus.err        = err_r;

endmodule
